mem_stage_pipe: RTL and testbench

- Parametrised, registered memory stage of the accumulator pipeline, between EX and WB.
- Executes STX/LDX against an internal synchronous data RAM with configurable read latency and passes ALU results through.
- Drives a MEM/WB output register.
- Valid/ready handshakes on both sides, so loads can stall EX and WB can back-pressure MEM.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/ram_sync_rd.sv | 84 ++++++++
 rtl/mem_stage_pipe.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the accumulator pipeline memory stage:
//   - operation select encodings carried on iOutMemSelect
//   - memory-stage FSM state type
//   - helpers to size the load-latency counter and decode the select field
// ---------------------------------------------------------------------------
package mem_pkg;

   // iOutMemSelect encodings. Bit [1] alone marks a store, so 2'b11 is also a store.
   localparam logic [1:0] SEL_STORE = 2'b10;
   localparam logic [1:0] SEL_ALU   = 2'b01;
   localparam logic [1:0] SEL_LOAD  = 2'b00;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   // Counter must hold READ_LAT-1; never narrower than one bit.
   function automatic int cnt_width(input int read_lat);
      if (read_lat > 1) begin
         return $clog2(read_lat);
      end else begin
         return 1;
      end
   endfunction

   function automatic logic sel_is_store(input logic [1:0] sel);
      return (sel[1] == SEL_STORE[1]);
   endfunction

   function automatic logic sel_is_load(input logic [1:0] sel);
      return (sel == SEL_LOAD);
   endfunction

endpackage

// File: rtl/ram_sync_rd.sv
// ---------------------------------------------------------------------------
// ram_sync_rd
// Single-port-write / registered-read data RAM with a configurable read
// latency. The read address is captured when i_re is high and then held;
// every cycle the held address is re-read into a (READ_LAT-1)-deep data
// pipeline, so once the pipeline has filled, o_rdata stays stable for as
// long as no new read is issued.
// Addresses >= DEPTH: writes are dropped, reads return zero.
//
// Ports:
//   Clock    in   clock, all state on rising edge
//   i_we     in   write enable
//   i_waddr  in   write address (ADDR_W)
//   i_wdata  in   write data (DATA_W)
//   i_re     in   capture i_raddr as the new read address
//   i_raddr  in   read address (ADDR_W)
//   o_rdata  out  read data, valid READ_LAT cycles after the capturing edge
// ---------------------------------------------------------------------------
module ram_sync_rd #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1
) (
   input  logic              Clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [ADDR_W-1:0] r_raddr;

   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic [IDX_W-1:0]  w_widx;
   logic [IDX_W-1:0]  w_ridx;
   logic [DATA_W-1:0] w_rd_word;

   assign w_wr_in_range = ({1'b0, i_waddr} < DEPTH_L);
   assign w_rd_in_range = ({1'b0, r_raddr} < DEPTH_L);
   assign w_widx        = i_waddr[IDX_W-1:0];
   assign w_ridx        = r_raddr[IDX_W-1:0];
   assign w_rd_word     = w_rd_in_range ? r_mem[w_ridx] : {DATA_W{1'b0}};

   // Write port; out-of-range stores are silently dropped. Contents are never cleared.
   always_ff @(posedge Clock) begin
      if (i_we && w_wr_in_range) begin
         r_mem[w_widx] <= i_wdata;
      end
   end

   // Read address register: loads on a new read, otherwise recirculates the held address.
   always_ff @(posedge Clock) begin
      if (i_re) begin
         r_raddr <= i_raddr;
      end
   end

   generate
      if (READ_LAT == 1) begin : g_lat1
         assign o_rdata = w_rd_word;
      end else begin : g_latn
         logic [DATA_W-1:0] r_pipe [0:READ_LAT-2];

         // Read-data delay line; keeps re-reading the held address every cycle.
         always_ff @(posedge Clock) begin
            r_pipe[0] <= w_rd_word;
            for (int k = 1; k < READ_LAT - 1; k++) begin
               r_pipe[k] <= r_pipe[k-1];
            end
         end

         assign o_rdata = r_pipe[READ_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe
// Registered MEM stage of the accumulator pipeline (between EX and WB).
// ALU results pass straight into the MEM/WB register; stores write the
// internal RAM and also pass the ALU result; loads read the RAM with
// READ_LAT cycles of latency, blocking EX until the data is in the register.
// Both sides use valid/ready handshakes.
//
// Ports:
//   Clock              in   clock
//   Reset              in   synchronous, active-high reset
//   iValid_EX          in   EX presents an instruction
//   oReady_MEM         out  MEM accepts this cycle (combinational on iReady_WB)
//   iAluDataEX         in   ALU result
//   iOutMemSelect      in   [1]=1 store, 01 ALU pass, 00 load
//   iDataWriteValue    in   store data
//   iAddresReadNWrite  in   load/store address
//   iControlAcum_EX    in   control bundle, forwarded unchanged
//   oValid_MEM         out  MEM/WB register holds a result
//   iReady_WB          in   WB consumes this cycle
//   oDataToWB          out  result data
//   oControlAcum_MEM   out  control bundle to WB
// ---------------------------------------------------------------------------
module mem_stage_pipe
   import mem_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 1024,
   parameter int CTRL_W   = 3,
   parameter int READ_LAT = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iValid_EX,
   output logic              oReady_MEM,
   input  logic [DATA_W-1:0] iAluDataEX,
   input  logic [1:0]        iOutMemSelect,
   input  logic [DATA_W-1:0] iDataWriteValue,
   input  logic [ADDR_W-1:0] iAddresReadNWrite,
   input  logic [CTRL_W-1:0] iControlAcum_EX,
   output logic              oValid_MEM,
   input  logic              iReady_WB,
   output logic [DATA_W-1:0] oDataToWB,
   output logic [CTRL_W-1:0] oControlAcum_MEM
);

   localparam int CNT_W = cnt_width(READ_LAT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CTRL_W-1:0] r_ld_ctrl;

   logic              w_slot_free;
   logic              w_accept;
   logic              w_is_store;
   logic              w_is_load;
   logic              w_we;
   logic              w_rd_issue;
   logic              w_load_alu;
   logic              w_load_ram;
   logic [DATA_W-1:0] w_rd_data;

   assign w_is_store  = sel_is_store(iOutMemSelect);
   assign w_is_load   = sel_is_load(iOutMemSelect);
   assign w_slot_free = !oValid_MEM | iReady_WB;
   // Reset gates ready so an accept cycle under reset never writes the RAM.
   assign oReady_MEM  = (r_state == S_IDLE) & w_slot_free & !Reset;
   assign w_accept    = iValid_EX & oReady_MEM;

   ram_sync_rd #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) u_ram (
      .Clock   (Clock),
      .i_we    (w_we),
      .i_waddr (iAddresReadNWrite),
      .i_wdata (iDataWriteValue),
      .i_re    (w_rd_issue),
      .i_raddr (iAddresReadNWrite),
      .o_rdata (w_rd_data)
   );

   // FSM state and load-latency counter register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next-state and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_is_load) begin
               w_state_nxt = S_LOAD;
               w_cnt_nxt   = CNT_W'(READ_LAT - 1);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            if (r_cnt != {CNT_W{1'b0}}) begin
               w_cnt_nxt = r_cnt - CNT_W'(1'b1);
            end else if (w_slot_free) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_LOAD;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM outputs: RAM strobes and MEM/WB register load selects.
   always_comb begin
      w_we       = 1'b0;
      w_rd_issue = 1'b0;
      w_load_alu = 1'b0;
      w_load_ram = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_we       = w_accept & w_is_store;
            w_rd_issue = w_accept & w_is_load;
            w_load_alu = w_accept & !w_is_load;
         end
         S_LOAD: begin
            // Counter at zero means the held read data is ready at the RAM output.
            w_load_ram = (r_cnt == {CNT_W{1'b0}}) & w_slot_free;
         end
         default: begin
            w_load_ram = 1'b0;
         end
      endcase
   end

   // Control bundle of the outstanding load, returned with its data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_ld_ctrl <= {CTRL_W{1'b0}};
      end else if (w_rd_issue) begin
         r_ld_ctrl <= iControlAcum_EX;
      end
   end

   // MEM/WB output register: reload, drain, or hold under back-pressure.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         oValid_MEM       <= 1'b0;
         oDataToWB        <= {DATA_W{1'b0}};
         oControlAcum_MEM <= {CTRL_W{1'b0}};
      end else if (w_load_alu) begin
         oValid_MEM       <= 1'b1;
         oDataToWB        <= iAluDataEX;
         oControlAcum_MEM <= iControlAcum_EX;
      end else if (w_load_ram) begin
         oValid_MEM       <= 1'b1;
         oDataToWB        <= w_rd_data;
         oControlAcum_MEM <= r_ld_ctrl;
      end else if (w_slot_free) begin
         oValid_MEM       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_pipe
// Two instances: u0 (DEPTH 1024, READ_LAT 1) and u1 (DEPTH 512, READ_LAT 3).
// A transaction-level reference model (memory array, pending-load record,
// output slot) predicts ready/valid/data each cycle; table vectors and
// hand-written sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_mem_stage_pipe;

   localparam int N = 2;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  [N];
   logic       vld  [N];
   logic       rdy  [N];
   logic [1:0] sel  [N];
   logic [7:0] alu  [N];
   logic [7:0] wd   [N];
   logic [9:0] addr [N];
   logic [2:0] ctrl [N];
   logic       ordy [N];
   logic       ovld [N];
   logic [7:0] odat [N];
   logic [2:0] octl [N];

   mem_stage_pipe #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .CTRL_W(3), .READ_LAT(1)) u_dut0 (
      .Clock(clk), .Reset(rst[0]), .iValid_EX(vld[0]), .oReady_MEM(ordy[0]),
      .iAluDataEX(alu[0]), .iOutMemSelect(sel[0]), .iDataWriteValue(wd[0]),
      .iAddresReadNWrite(addr[0]), .iControlAcum_EX(ctrl[0]), .oValid_MEM(ovld[0]),
      .iReady_WB(rdy[0]), .oDataToWB(odat[0]), .oControlAcum_MEM(octl[0]));

   mem_stage_pipe #(.DATA_W(8), .ADDR_W(10), .DEPTH(512), .CTRL_W(3), .READ_LAT(3)) u_dut1 (
      .Clock(clk), .Reset(rst[1]), .iValid_EX(vld[1]), .oReady_MEM(ordy[1]),
      .iAluDataEX(alu[1]), .iOutMemSelect(sel[1]), .iDataWriteValue(wd[1]),
      .iAddresReadNWrite(addr[1]), .iControlAcum_EX(ctrl[1]), .oValid_MEM(ovld[1]),
      .iReady_WB(rdy[1]), .oDataToWB(odat[1]), .oControlAcum_MEM(octl[1]));

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_mem [N][1024];
   bit m_ov  [N];
   int m_od  [N];
   int m_oc  [N];
   bit m_lp  [N];
   int m_lw  [N];
   int m_ld  [N];
   int m_lc  [N];

   bit          t_acc [N];
   logic [10:0] got0 [$];
   logic [10:0] got1 [$];

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int dep_of(int i);
      return (i == 0) ? 1024 : 512;
   endfunction

   function automatic bit m_ready(int i);
      return !m_lp[i] && (!m_ov[i] || rdy[i]) && !rst[i];
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_step(int i);
      bit sf     = !m_ov[i] || rdy[i];
      bit acc    = vld[i] && m_ready(i);
      bit loaded = 1'b0;
      int a      = int'(addr[i]);
      if (rst[i]) begin
         m_ov[i] = 1'b0; m_od[i] = 0; m_oc[i] = 0; m_lp[i] = 1'b0; m_lw[i] = 0;
      end else begin
         if (m_lp[i]) begin
            if (m_lw[i] > 0) m_lw[i]--;
            else if (sf) begin
               m_od[i] = m_ld[i]; m_oc[i] = m_lc[i]; m_ov[i] = 1'b1;
               loaded = 1'b1; m_lp[i] = 1'b0;
            end
         end else if (acc) begin
            if (sel[i] == 2'b00) begin
               m_lp[i] = 1'b1;
               m_lw[i] = lat_of(i) - 1;
               m_ld[i] = (a < dep_of(i)) ? m_mem[i][a] : 0;
               m_lc[i] = int'(ctrl[i]);
            end else begin
               if (sel[i][1] && a < dep_of(i)) m_mem[i][a] = int'(wd[i]);
               m_od[i] = int'(alu[i]); m_oc[i] = int'(ctrl[i]); m_ov[i] = 1'b1;
               loaded = 1'b1;
            end
         end
         if (!loaded && sf) m_ov[i] = 1'b0;
      end
   endtask

   // one clock: check ready, record deliveries, advance model, check registers
   task automatic tick();
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d_ready", i), ordy[i], m_ready(i));
         t_acc[i] = vld[i] && ordy[i];
      end
      if (ovld[0] && rdy[0]) got0.push_back({octl[0], odat[0]});
      if (ovld[1] && rdy[1]) got1.push_back({octl[1], odat[1]});
      @(posedge clk);
      for (int i = 0; i < N; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d_valid", i), ovld[i], m_ov[i]);
         if (m_ov[i]) begin
            chk($sformatf("u%0d_data", i), odat[i], m_od[i]);
            chk($sformatf("u%0d_ctrl", i), octl[i], m_oc[i]);
         end
      end
   endtask

   task automatic op(int i, logic [1:0] s, logic [7:0] a, logic [7:0] w, logic [9:0] ad, logic [2:0] c);
      vld[i] = 1'b1; sel[i] = s; alu[i] = a; wd[i] = w; addr[i] = ad; ctrl[i] = c;
   endtask

   task automatic nop(int i);
      vld[i] = 1'b0;
   endtask

   task automatic wait_valid(int i, int budget, string nm);
      int n = 0;
      while (ovld[i] !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(nm, ovld[i], 1'b1);
   endtask

   typedef struct {
      logic [1:0] s;
      logic [7:0] a;
      logic [7:0] w;
      logic [9:0] ad;
      logic [2:0] c;
      logic [7:0] exp_d;
      logic [2:0] exp_c;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] svals [8];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int k;
      tbl[0] = '{2'b01, 8'h5A, 8'h00, 10'h000, 3'b101, 8'h5A, 3'b101};
      tbl[1] = '{2'b10, 8'h11, 8'hC3, 10'h2A5, 3'b010, 8'h11, 3'b010};
      tbl[2] = '{2'b01, 8'hFF, 8'h00, 10'h000, 3'b111, 8'hFF, 3'b111};
      tbl[3] = '{2'b11, 8'h00, 8'h3C, 10'h005, 3'b000, 8'h00, 3'b000};
      tbl[4] = '{2'b01, 8'h80, 8'h00, 10'h000, 3'b001, 8'h80, 3'b001};
      tbl[5] = '{2'b10, 8'hA5, 8'h77, 10'h010, 3'b110, 8'hA5, 3'b110};

      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1; vld[i] = 1'b0; rdy[i] = 1'b1; sel[i] = 2'b01;
         alu[i] = 8'h00; wd[i] = 8'h00; addr[i] = 10'h000; ctrl[i] = 3'b000;
         m_ov[i] = 1'b0; m_od[i] = 0; m_oc[i] = 0; m_lp[i] = 1'b0; m_lw[i] = 0;
         m_ld[i] = 0; m_lc[i] = 0;
         for (int j = 0; j < 1024; j++) m_mem[i][j] = -1;
      end

      // reset state
      @(negedge clk);
      tick(); tick();
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk("rst_valid", ovld[i], 1'b0);
         chk("rst_data", odat[i], 8'h00);
         chk("rst_ctrl", octl[i], 3'b000);
      end
      #1;
      chk("rst_ready0", ordy[0], 1'b1);
      chk("rst_ready1", ordy[1], 1'b1);

      // table vectors: back-to-back ALU/store on u0, WB always ready
      foreach (tbl[v]) begin
         op(0, tbl[v].s, tbl[v].a, tbl[v].w, tbl[v].ad, tbl[v].c);
         tick();
         chk("tbl_valid", ovld[0], 1'b1);
         chk("tbl_data", odat[0], tbl[v].exp_d);
         chk("tbl_ctrl", octl[0], tbl[v].exp_c);
      end

      // store then load same address, READ_LAT=1
      op(0, 2'b10, 8'h21, 8'hC3, 10'h2A5, 3'b100); tick();
      op(0, 2'b00, 8'h00, 8'h00, 10'h2A5, 3'b011); tick();
      nop(0);
      #1 chk("ld1_busy", ordy[0], 1'b0);
      tick();
      chk("ld1_valid", ovld[0], 1'b1);
      chk("ld1_data", odat[0], 8'hC3);
      chk("ld1_ctrl", octl[0], 3'b011);
      #1 chk("ld1_ready", ordy[0], 1'b1);
      tick();

      // back-pressure on a READ_LAT=3 load
      op(1, 2'b10, 8'h00, 8'h77, 10'h010, 3'b001); tick();
      op(1, 2'b00, 8'h00, 8'h00, 10'h010, 3'b101); tick();
      nop(1); rdy[1] = 1'b0;
      got1.delete();
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("bp_valid", ovld[1], (j >= 2) ? 1'b1 : 1'b0);
         chk("bp_ready", ordy[1], 1'b0);
         if (j >= 2) chk("bp_data", odat[1], 8'h77);
      end
      rdy[1] = 1'b1;
      tick();
      chk("bp_drained", ovld[1], 1'b0);
      tick();
      chk("bp_count", got1.size(), 1);
      if (got1.size() > 0) chk("bp_value", got1[0], {3'b101, 8'h77});

      // out-of-range store dropped (0x300 aliases 0x100 if wrapped)
      op(1, 2'b10, 8'h00, 8'h5E, 10'h100, 3'b000); tick();
      op(1, 2'b10, 8'h00, 8'hFF, 10'h300, 3'b000); tick();
      op(1, 2'b00, 8'h00, 8'h00, 10'h300, 3'b010); tick();
      nop(1);
      wait_valid(1, 8, "oor_wait");
      chk("oor_data", odat[1], 8'h00);
      chk("oor_ctrl", octl[1], 3'b010);
      op(1, 2'b00, 8'h00, 8'h00, 10'h100, 3'b011); tick();
      nop(1);
      wait_valid(1, 8, "inr_wait");
      chk("inr_data", odat[1], 8'h5E);

      // reset while a load is in flight
      op(1, 2'b00, 8'h00, 8'h00, 10'h010, 3'b111); tick();
      nop(1); tick();
      rst[1] = 1'b1; tick(); rst[1] = 1'b0;
      chk("rml_valid", ovld[1], 1'b0);
      chk("rml_data", odat[1], 8'h00);
      chk("rml_ctrl", octl[1], 3'b000);
      #1 chk("rml_ready", ordy[1], 1'b1);
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("rml_quiet", ovld[1], 1'b0);
      end

      // stream of 8 ALU ops with WB ready toggling
      for (int j = 0; j < 8; j++) svals[j] = 8'(8'h31 + 8'(j) * 8'h11);
      got0.delete();
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
         rdy[0] = (cyc % 2 == 0);
         op(0, 2'b01, svals[k], 8'h00, 10'h000, 3'(k));
         tick();
         if (t_acc[0]) k++;
      end
      chk("stream_sent", k, 8);
      nop(0); rdy[0] = 1'b1;
      tick(); tick(); tick();
      chk("stream_count", got0.size(), 8);
      for (int j = 0; j < got0.size() && j < 8; j++)
         chk("stream_order", got0[j], {3'(j), svals[j]});

      // preload low addresses, then randomized traffic on both instances
      for (int a = 0; a < 16; a++) begin
         for (int i = 0; i < N; i++)
            op(i, 2'b10, 8'($urandom), 8'($urandom), 10'(a), 3'($urandom));
         tick();
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            logic [9:0] ad;
            rst[i] = ($urandom_range(0, 79) == 0);
            rdy[i] = ($urandom_range(0, 2) != 0);
            if (i == 1 && $urandom_range(0, 3) == 0) ad = 10'(512 + $urandom_range(0, 15));
            else ad = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0)
               op(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), ad, 3'($urandom));
            else
               nop(i);
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b0; rdy[i] = 1'b1; nop(i);
      end
      for (int j = 0; j < 6; j++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
